// File: rtl/snax_clint_pkg.sv
// Shared register-map constants, request/response records and the byte-strobe merge helper
// for the snax core-local interruptor.
package snax_clint_pkg;

    localparam logic [15:0] MsipBase     = 16'h0000;
    localparam logic [15:0] MtimecmpBase = 16'h4000;
    localparam logic [15:0] MtimeOffset  = 16'hBFF8;

    // Only the low 16 address bits are decoded, so the record carries the word-aligned offset.
    typedef struct packed {
        logic [15:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  strb;
    } clint_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
    } clint_rsp_t;

    function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/snax_clint_rtc_sync.sv
// Optional two-flop synchronizer for the RTC input followed by a rising-edge detector;
// tick_o pulses for one clk_i cycle per rtc_i rising edge.
module snax_clint_rtc_sync #(
    parameter bit RtcSync = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rtc_i,
    output logic tick_o
);

    logic rtc_level;
    logic rtc_prev_q;

    generate
        if (RtcSync) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) sync_q <= 2'b00;
                else         sync_q <= {sync_q[0], rtc_i};
            end
            assign rtc_level = sync_q[1];
        end else begin : g_nosync
            assign rtc_level = rtc_i;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rtc_prev_q <= 1'b0;
        else         rtc_prev_q <= rtc_level;
    end

    assign tick_o = rtc_level & ~rtc_prev_q;

endmodule

// File: rtl/snax_clint.sv
// Core-local interruptor: per-hart msip bits, per-hart mtimecmp and a global mtime behind a
// single-outstanding valid/ready register port.
module snax_clint
    import snax_clint_pkg::*;
#(
    parameter int unsigned NrCores   = 1,
    parameter int unsigned AddrWidth = 48,
    parameter bit          RtcSync   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rtc_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    input  logic [63:0]          req_wdata_i,
    input  logic [7:0]           req_strb_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [63:0]          rsp_rdata_o,
    output logic                 rsp_error_o,
    output logic [NrCores-1:0]   msip_o,
    output logic [NrCores-1:0]   mtip_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StResp = 1'b1;

    logic [0:0]   state_q, state_d;
    clint_req_t   req;
    clint_rsp_t   rsp_q, rsp_d;
    logic         tick;
    logic [63:0]  mtime_q, mtime_d, mtime_inc;
    logic [63:0]  mtimecmp_arr [NrCores];
    logic [NrCores-1:0] msip_vec, mtip_vec;
    logic [10:0]  slot;
    logic         msip_sel, cmp_sel, mtime_sel, decode_err, accept, wr_en;
    logic [63:0]  rdata_rd;
    logic         unused_addr;

    assign req = '{addr: {req_addr_i[15:3], 3'b000}, write: req_write_i,
                   wdata: req_wdata_i, strb: req_strb_i};
    assign unused_addr = ^req_addr_i;

    // Each msip word holds two harts, so the slot is valid while its even hart exists.
    assign slot       = req.addr[13:3];
    assign msip_sel   = (req.addr[15:14] == MsipBase[15:14]) && ({slot, 1'b0} < 12'(NrCores));
    assign cmp_sel    = (req.addr[15:14] == MtimecmpBase[15:14]) && (slot < 11'(NrCores));
    assign mtime_sel  = (req.addr == MtimeOffset);
    assign decode_err = ~(msip_sel | cmp_sel | mtime_sel);
    assign accept     = req_valid_i && (state_q == StIdle);
    assign wr_en      = accept && req.write && !decode_err;

    snax_clint_rtc_sync #(.RtcSync(RtcSync)) i_rtc_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rtc_i  (rtc_i),
        .tick_o (tick)
    );

    // A write coinciding with a tick merges against the already-incremented count.
    assign mtime_inc = tick ? mtime_q + 64'd1 : mtime_q;
    assign mtime_d   = (wr_en && mtime_sel) ? strb_merge(mtime_inc, req.wdata, req.strb) : mtime_inc;

    genvar gi;
    generate
        for (gi = 0; gi < int'(NrCores); gi++) begin : g_hart
            localparam int Half = gi % 2;
            logic        msip_q, msip_d, mtip_q, cmp_we;
            logic [63:0] cmp_q, cmp_d;

            assign cmp_we = wr_en && cmp_sel && (slot == 11'(gi));
            assign cmp_d  = cmp_we ? strb_merge(cmp_q, req.wdata, req.strb) : cmp_q;
            assign msip_d = (wr_en && msip_sel && (slot == 11'(gi / 2)) && req.strb[4*Half])
                            ? req.wdata[32*Half] : msip_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    msip_q <= 1'b0;
                    cmp_q  <= '1;
                    mtip_q <= 1'b0;
                end else begin
                    msip_q <= msip_d;
                    cmp_q  <= cmp_d;
                    mtip_q <= (mtime_q >= cmp_q);
                end
            end

            assign msip_vec[gi]     = msip_q;
            assign mtip_vec[gi]     = mtip_q;
            assign mtimecmp_arr[gi] = cmp_q;
        end
    endgenerate

    always_comb begin
        rdata_rd = '0;
        for (int h = 0; h < int'(NrCores); h++) begin
            if (msip_sel && (slot == 11'(h / 2))) rdata_rd[32*(h%2)] = msip_vec[h];
            if (cmp_sel && (slot == 11'(h)))      rdata_rd = mtimecmp_arr[h];
        end
        if (mtime_sel) rdata_rd = mtime_q;
    end

    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        if (state_q == StIdle) begin
            if (accept) begin
                state_d     = StResp;
                rsp_d.error = decode_err;
                rsp_d.rdata = (req.write || decode_err) ? 64'd0 : rdata_rd;
            end
        end else if (rsp_ready_i) begin
            state_d = StIdle;
            rsp_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rsp_q   <= '0;
            mtime_q <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            mtime_q <= mtime_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_error_o = rsp_q.error;
    assign msip_o      = msip_vec;
    assign mtip_o      = mtip_vec;

endmodule

// File: tb/tb_snax_clint.sv
// Directed and randomized checks of snax_clint (4 harts, synchronized RTC) against an
// array-based model of the register map.
module tb_snax_clint;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rtc = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [47:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic [N-1:0] msip, mtip;

    int tests = 0;
    int fails = 0;

    logic [63:0]  m_mtime;
    logic [63:0]  m_cmp [N];
    logic [N-1:0] m_msip;

    snax_clint #(.NrCores(N), .AddrWidth(48), .RtcSync(1'b1)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rtc_i       (rtc),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .req_strb_i  (req_strb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .msip_o      (msip),
        .mtip_o      (mtip)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] st);
        logic [63:0] r;
        r = old_v;
        for (int b = 0; b < 8; b++) if (st[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic void model_reset();
        m_mtime = '0;
        m_msip  = '0;
        for (int h = 0; h < N; h++) m_cmp[h] = '1;
    endfunction

    function automatic logic [N-1:0] exp_mtip();
        logic [N-1:0] r;
        for (int h = 0; h < N; h++) r[h] = (m_mtime >= m_cmp[h]);
        return r;
    endfunction

    function automatic void model_access(input bit wr, input logic [15:0] addr,
                                         input logic [63:0] wd, input logic [7:0] st,
                                         output logic [63:0] rd, output logic er);
        int off, w, h;
        off = int'(addr) & 'hFFF8;
        rd = '0;
        er = 1'b0;
        if (off < 'h4000) begin
            w = off / 8;
            if (2*w >= N) er = 1'b1;
            else if (wr) begin
                if (st[0]) m_msip[2*w] = wd[0];
                if (st[4] && (2*w+1 < N)) m_msip[2*w+1] = wd[32];
            end else begin
                rd[0] = m_msip[2*w];
                if (2*w+1 < N) rd[32] = m_msip[2*w+1];
            end
        end else if (off < 'h4000 + 8*N) begin
            h = (off - 'h4000) / 8;
            if (wr) m_cmp[h] = merge(m_cmp[h], wd, st);
            else    rd = m_cmp[h];
        end else if (off == 'hBFF8) begin
            if (wr) m_mtime = merge(m_mtime, wd, st);
            else    rd = m_mtime;
        end else begin
            er = 1'b1;
        end
    endfunction

    // One request with rsp_ready high; returns at the negedge after acceptance.
    task automatic txn(input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                       input logic [7:0] st, output logic [63:0] rd, output logic er);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = {32'($urandom), addr};
        req_wdata = wd;
        req_strb  = st;
        @(negedge clk);
        req_valid = 1'b0;
        check("rsp_valid_latency", rsp_valid, 1'b1);
        rd = rsp_rdata;
        er = rsp_error;
    endtask

    task automatic acc(input bit wr, input logic [15:0] addr, input logic [63:0] wd,
                       input logic [7:0] st, input string tag);
        logic [63:0] rd, erd;
        logic er, eer;
        txn(wr, addr, wd, st, rd, er);
        model_access(wr, addr, wd, st, erd, eer);
        check({tag, "_rdata"}, rd, erd);
        check({tag, "_error"}, er, eer);
        @(negedge clk);
        check({tag, "_msip"}, msip, m_msip);
        check({tag, "_mtip"}, mtip, exp_mtip());
        $display("[TB] %s wr=%0d addr=%h wdata=%h strb=%h -> rdata=%h err=%0d",
                 tag, wr, addr, wd, st, rd, er);
    endtask

    task automatic rtc_pulse();
        @(negedge clk);
        rtc = 1'b1;
        repeat (4) @(negedge clk);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        m_mtime = m_mtime + 64'd1;
    endtask

    initial begin
        logic [15:0] a;
        logic [63:0] wd;
        logic [7:0]  st;
        int k;

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        check("reset_rsp_error", rsp_error, 1'b0);
        check("reset_msip", msip, 4'b0000);
        check("reset_mtip", mtip, 4'b0000);
        rst_n = 1'b1;

        acc(1'b0, 16'hBFF8, 64'd0, 8'h00, "rd_mtime_reset");
        acc(1'b0, 16'h4000, 64'd0, 8'h00, "rd_cmp0_reset");

        acc(1'b1, 16'h0000, 64'h1_0000_0001, 8'hFF, "wr_msip01");
        check("msip_0011", msip, 4'b0011);
        acc(1'b1, 16'h0008, 64'h1_0000_0000, 8'hF0, "wr_msip23");
        check("msip_1011", msip, 4'b1011);

        acc(1'b1, 16'h4008, 64'd5, 8'hFF, "wr_cmp1");
        repeat (4) begin
            rtc_pulse();
            check("mtip_below_cmp", mtip, 4'b0000);
        end
        @(negedge clk);
        rtc = 1'b1;
        repeat (3) @(negedge clk);
        check("mtip_lags_mtime", mtip, 4'b0000);
        @(negedge clk);
        check("mtip1_rises", mtip, 4'b0010);
        rtc = 1'b0;
        repeat (4) @(negedge clk);
        m_mtime = m_mtime + 64'd1;
        acc(1'b0, 16'hBFF8, 64'd0, 8'h00, "rd_mtime_5");
        check("mtime_is_5", m_mtime, 64'd5);

        acc(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "wr_mtime_max");
        rtc_pulse();
        acc(1'b0, 16'hBFF8, 64'd0, 8'h00, "rd_mtime_wrap");

        acc(1'b1, 16'hBFF8, 64'h1FF, 8'hFF, "wr_mtime_1ff");
        @(negedge clk);
        rtc = 1'b1;
        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 48'h0000_0000_BFF8;
        req_wdata = 64'h10;
        req_strb  = 8'h01;
        @(negedge clk);
        req_valid = 1'b0;
        rtc = 1'b0;
        check("tick_write_rsp_valid", rsp_valid, 1'b1);
        repeat (4) @(negedge clk);
        m_mtime = 64'h210;
        acc(1'b0, 16'hBFF8, 64'd0, 8'h00, "rd_mtime_merged");

        acc(1'b0, 16'h4020, 64'd0, 8'h00, "rd_cmp4_err");
        acc(1'b1, 16'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "wr_bad_addr");
        acc(1'b1, 16'hBFF8, 64'hDEAD, 8'h00, "wr_strb0");
        acc(1'b0, 16'h0000, 64'd0, 8'h00, "rd_msip01");
        acc(1'b0, 16'h0008, 64'd0, 8'h00, "rd_msip23");

        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 48'h0000_0000_BFF8;
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 48'h0;
        req_wdata = 64'd0;
        req_strb  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_rdata", rsp_rdata, m_mtime);
            check("stall_rsp_error", rsp_error, 1'b0);
            check("stall_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("stall_release_valid", rsp_valid, 1'b0);
        check("stall_msip_kept", msip, m_msip);
        $display("[TB] stall read mtime held 5 cycles");

        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 48'h0000_0000_4000;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_reset_rsp_valid", rsp_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_drops_rsp", rsp_valid, 1'b0);
        check("reset_req_ready_mid", req_ready, 1'b1);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("post_reset_msip", msip, 4'b0000);
        $display("[TB] reset asserted during response");
        acc(1'b0, 16'hBFF8, 64'd0, 8'h00, "rd_mtime_post_reset");
        acc(1'b0, 16'h4008, 64'd0, 8'h00, "rd_cmp1_post_reset");

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 2)      a = 16'(k * 8);
            else if (k <= 7) a = 16'h4000 + 16'((k - 3) * 8);
            else if (k == 8) a = 16'hBFF8;
            else begin
                case ($urandom_range(0, 4))
                    0: a = 16'h1234;
                    1: a = 16'h8000;
                    2: a = 16'hBFF0;
                    3: a = 16'hC000;
                    default: a = 16'h3FF8;
                endcase
            end
            a = a | 16'($urandom_range(0, 7));
            wd = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 12)) : {$urandom, $urandom};
            st = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            acc(1'($urandom_range(0, 1)), a, wd, st, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
